// File: rtl/icache_responder.sv
// Direct-mapped, blocking, one-word-block instruction cache between the datapath
// fetch port and the memory controller. Hits return in the same cycle; misses stall until the fill completes.
module icache_responder #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dp_imemREN,
    input  logic [WORD_W-1:0] dp_imemaddr,
    output logic              dp_ihit,
    output logic [WORD_W-1:0] dp_imemload,
    output logic              mem_iREN,
    output logic [WORD_W-1:0] mem_iaddr,
    input  logic              mem_iwait,
    input  logic [WORD_W-1:0] mem_iload,
    output logic [WORD_W-1:0] hit_count,
    output logic [WORD_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [WORD_W-1:0] r_data [SETS];
    logic [WORD_W-1:0] r_miss_addr;
    logic [WORD_W-1:0] r_hit_count;
    logic [WORD_W-1:0] r_miss_count;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_miss_idx;
    logic [TAG_W-1:0]  w_miss_tag;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill;
    logic              w_unused_offset;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (&v) ? v : v + WORD_W'(1);
    endfunction

    assign w_idx      = dp_imemaddr[IDX_W+1:2];
    assign w_tag      = dp_imemaddr[WORD_W-1:IDX_W+2];
    assign w_miss_idx = r_miss_addr[IDX_W+1:2];
    assign w_miss_tag = r_miss_addr[WORD_W-1:IDX_W+2];
    // Byte offsets never select anything: blocks are a single word.
    assign w_unused_offset = ^{dp_imemaddr[1:0], r_miss_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            IDLE: begin
                w_hit = dp_imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
                if (dp_imemREN && !w_hit) begin
                    w_miss      = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (!mem_iwait) begin
                    w_fill      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign dp_ihit     = w_hit;
    assign dp_imemload = w_hit ? r_data[w_idx] : '0;
    assign mem_iREN    = (r_state == FETCH);
    assign mem_iaddr   = r_miss_addr;
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_miss_addr <= {w_tag, w_idx, 2'b00};
            end
            if (w_fill) begin
                r_valid[w_miss_idx] <= 1'b1;
                r_miss_count        <= sat_inc(r_miss_count);
            end
            if (w_hit) begin
                r_hit_count <= sat_inc(r_hit_count);
            end
        end
    end

    // Tag/data are only meaningful behind a valid bit, so a fill racing reset is harmless.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= mem_iload;
        end
    end

endmodule
